latch_bank_arbiter: RTL

//  Shares one gated D-latch bank (d/g/clr interface) between NREQ requesters.

---
 rtl/latch_bank_arbiter.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/latch_bank_arbiter.sv
// Round-robin arbiter driving a shared gated D-latch bank.
// Optional bank clear sequence: define LATCH_ARB_CLR_EN.
module latch_bank_arbiter #(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int SETUP_CYC = 1,
  parameter int GATE_CYC  = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] wdat,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               busy,
  output logic [DW-1:0]      lat_d,
  output logic               lat_g,
  output logic               lat_clr
`ifdef LATCH_ARB_CLR_EN
  ,
  input  logic               clr_req,
  output logic               clr_ack
`endif
);

  localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int MAXC = (SETUP_CYC > GATE_CYC) ? SETUP_CYC : GATE_CYC;
  localparam int CW   = $clog2(MAXC) + 1;

  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] GATE_LD  = CW'(GATE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    GATE,
    HOLD
`ifdef LATCH_ARB_CLR_EN
    ,
    CLEAR
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [DW-1:0]   lat_d_q, lat_d_d;
  logic            lat_g_q, lat_g_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
`ifdef LATCH_ARB_CLR_EN
  logic            lat_clr_q, lat_clr_d;
  logic            clr_ack_q, clr_ack_d;
`endif

  logic [DW-1:0]   slot [NREQ];
  logic            arb_en;
  logic [NREQ-1:0] arb_req;
  logic [IW-1:0]   arb_ptr;
  logic [IW-1:0]   nxt_ptr;
  logic [NREQ-1:0] win_oh;
  logic            in_txn;

  // First set bit at or after p, wrapping from NREQ-1 to 0.
  function automatic logic [IW-1:0] rr_pick(
    input logic [NREQ-1:0] r,
    input logic [IW-1:0]   p
  );
    logic [IW-1:0] sel;
    logic          hit;
    int            idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(p) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!hit && r[IW'(idx)]) begin
        hit = 1'b1;
        sel = IW'(idx);
      end
    end
    return sel;
  endfunction

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      slot[i] = wdat[i*DW +: DW];
    end
  end

  assign nxt_ptr = (win_q == IW'(NREQ - 1)) ?
                   '0 : win_q + IW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    lat_d_d = lat_d_q;
    arb_en  = 1'b0;
    arb_req = req;
    arb_ptr = ptr_q;

    unique case (state_q)
      IDLE: begin
        arb_en = 1'b1;
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = GATE;
          cnt_d   = GATE_LD;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GATE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      HOLD: begin
        // current winner cannot chain into itself
        ptr_d   = nxt_ptr;
        arb_ptr = nxt_ptr;
        arb_req = req & ~gnt_q;
        arb_en  = 1'b1;
      end
`ifdef LATCH_ARB_CLR_EN
      CLEAR: begin
        arb_en = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    if (arb_en) begin
      if (|arb_req) begin
        win_d   = rr_pick(arb_req, arb_ptr);
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        lat_d_d = slot[win_d];
      end else begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end

`ifdef LATCH_ARB_CLR_EN
    if (clr_req && (state_q == IDLE || state_q == HOLD)) begin
      state_d = CLEAR;
      cnt_d   = '0;
      win_d   = win_q;
      lat_d_d = '0;
    end
`endif
  end

  always_comb begin
    win_oh = NREQ'(1) << win_d;
    in_txn = (state_d == SETUP) ||
             (state_d == GATE)  ||
             (state_d == HOLD);
    gnt_d   = in_txn ? win_oh : '0;
    done_d  = (state_d == HOLD) ? win_oh : '0;
    lat_g_d = (state_d == GATE);
    busy_d  = (state_d != IDLE);
`ifdef LATCH_ARB_CLR_EN
    lat_clr_d = (state_d == CLEAR);
    clr_ack_d = (state_d == CLEAR);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      win_q     <= '0;
      lat_d_q   <= '0;
      lat_g_q   <= 1'b0;
      gnt_q     <= '0;
      done_q    <= '0;
      busy_q    <= 1'b0;
`ifdef LATCH_ARB_CLR_EN
      lat_clr_q <= 1'b0;
      clr_ack_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      win_q     <= win_d;
      lat_d_q   <= lat_d_d;
      lat_g_q   <= lat_g_d;
      gnt_q     <= gnt_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
`ifdef LATCH_ARB_CLR_EN
      lat_clr_q <= lat_clr_d;
      clr_ack_q <= clr_ack_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign busy  = busy_q;
  assign lat_d = lat_d_q;
  assign lat_g = lat_g_q;
`ifdef LATCH_ARB_CLR_EN
  assign lat_clr = lat_clr_q;
  assign clr_ack = clr_ack_q;
`else
  assign lat_clr = 1'b0;
`endif

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!rst_n)
    $onehot0(gnt_q));

  a_g_clr_excl: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(lat_g && lat_clr));

endmodule
